// File: rtl/tensor_core_scheduler_if.sv
// Client-side bundle of the tensor core scheduler: job requests in, per-client results out.
// The master modport is the client side; the slave modport is the scheduler.
interface tensor_core_scheduler_if #(
  parameter int NUM_REQUESTERS = 2,
  parameter int DATA_WIDTH     = 8
);

  logic [NUM_REQUESTERS-1:0]                            req_valid;
  logic [NUM_REQUESTERS-1:0]                            req_ready;
  logic [NUM_REQUESTERS-1:0][2:0]                       req_op;
  logic [NUM_REQUESTERS-1:0][2:0][2:0][DATA_WIDTH-1:0]  req_matrix1;
  logic [NUM_REQUESTERS-1:0][2:0][2:0][DATA_WIDTH-1:0]  req_matrix2;
  logic [NUM_REQUESTERS-1:0]                            rsp_valid;
  logic [NUM_REQUESTERS-1:0]                            rsp_ready;
  logic                                                 rsp_error;
  logic [2:0][2:0][DATA_WIDTH-1:0]                      rsp_matrix;
  logic                                                 busy;

  modport master (
    output req_valid, req_op, req_matrix1, req_matrix2, rsp_ready,
    input  req_ready, rsp_valid, rsp_error, rsp_matrix, busy
  );

  modport slave (
    input  req_valid, req_op, req_matrix1, req_matrix2, rsp_ready,
    output req_ready, rsp_valid, rsp_error, rsp_matrix, busy
  );

endinterface

// File: rtl/tensor_core_scheduler.sv
// Round-robin front end sharing one small_tensor_core between several clients:
// accept a job, launch the core, wait out its latency, return the 3x3 result.
module tensor_core_scheduler #(
  parameter int NUM_REQUESTERS = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int CORE_LATENCY   = 11
) (
  input  logic                             clock_in,
  input  logic                             reset_in,
  tensor_core_scheduler_if.slave           sched,
  output logic                             core_start,
  output logic [2:0]                       core_op_select,
  output logic [2:0][2:0][DATA_WIDTH-1:0]  core_input1,
  output logic [2:0][2:0][DATA_WIDTH-1:0]  core_input2,
  input  logic [2:0][2:0][DATA_WIDTH-1:0]  core_output
);

  localparam int ID_W  = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int CNT_W = $clog2(CORE_LATENCY);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LAUNCH  = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

  typedef logic [2:0][2:0][DATA_WIDTH-1:0] mat_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b010: op_is_legal = 1'b1;
      default:                op_is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [NUM_REQUESTERS-1:0] id_onehot(input logic [ID_W-1:0] id);
    id_onehot     = '0;
    id_onehot[id] = 1'b1;
  endfunction

  logic [1:0]                state_r;
  logic [ID_W-1:0]           rr_ptr_r;
  logic [ID_W-1:0]           id_r;
  logic [CNT_W-1:0]          cnt_r;
  logic [2:0]                op_r;
  mat_t                      m1_r;
  mat_t                      m2_r;
  mat_t                      result_r;
  logic                      err_r;
  logic                      core_start_r;
  logic                      busy_r;
  logic [NUM_REQUESTERS-1:0] rsp_valid_r;

  logic                      grant_found_s;
  logic [ID_W-1:0]           grant_id_s;
  logic [ID_W:0]             idx_s;
  logic                      hit_s;
  logic [ID_W-1:0]           next_ptr_s;
  logic                      grant_legal_s;
  logic                      rsp_done_s;
  logic                      run_last_s;

  // Round-robin search: first requester at or after the pointer, wrapping modulo the client count
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    idx_s         = '0;
    hit_s         = 1'b0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      idx_s = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
      idx_s = (idx_s >= (ID_W+1)'(NUM_REQUESTERS)) ? idx_s - (ID_W+1)'(NUM_REQUESTERS) : idx_s;
      hit_s = !grant_found_s && sched.req_valid[idx_s[ID_W-1:0]];
      grant_id_s    = hit_s ? idx_s[ID_W-1:0] : grant_id_s;
      grant_found_s = grant_found_s | hit_s;
    end
  end

  assign next_ptr_s    = (grant_id_s == ID_W'(NUM_REQUESTERS - 1)) ? '0 : grant_id_s + ID_W'(1);
  assign grant_legal_s = op_is_legal(sched.req_op[grant_id_s]);
  assign rsp_done_s    = |(sched.rsp_ready & rsp_valid_r);
  assign run_last_s    = (cnt_r == CNT_W'(CORE_LATENCY - 1));

  // One-hot grant, offered only while idle and never during reset
  always_comb begin
    sched.req_ready = '0;
    if ((state_r == ST_IDLE) && !reset_in && grant_found_s) begin
      sched.req_ready = id_onehot(grant_id_s);
    end else begin
      sched.req_ready = '0;
    end
  end

  // Job FSM; operands stay latched so the core inputs hold until the next accept
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= '0;
      id_r         <= '0;
      cnt_r        <= '0;
      op_r         <= 3'b000;
      m1_r         <= '0;
      m2_r         <= '0;
      result_r     <= '0;
      err_r        <= 1'b0;
      core_start_r <= 1'b0;
      busy_r       <= 1'b0;
      rsp_valid_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_found_s) begin
            id_r     <= grant_id_s;
            rr_ptr_r <= next_ptr_s;
            op_r     <= sched.req_op[grant_id_s];
            m1_r     <= sched.req_matrix1[grant_id_s];
            m2_r     <= sched.req_matrix2[grant_id_s];
            err_r    <= !grant_legal_s;
            busy_r   <= 1'b1;
            if (grant_legal_s) begin
              core_start_r <= 1'b1;
              state_r      <= ST_LAUNCH;
            end else begin
              // Illegal op bypasses the core entirely and answers with a zero matrix
              result_r    <= '0;
              rsp_valid_r <= id_onehot(grant_id_s);
              state_r     <= ST_RESPOND;
            end
          end
        end
        ST_LAUNCH: begin
          core_start_r <= 1'b0;
          cnt_r        <= '0;
          state_r      <= ST_RUN;
        end
        ST_RUN: begin
          if (run_last_s) begin
            result_r    <= core_output;
            rsp_valid_r <= id_onehot(id_r);
            state_r     <= ST_RESPOND;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RESPOND: begin
          if (rsp_done_s) begin
            rsp_valid_r <= '0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          core_start_r <= 1'b0;
          rsp_valid_r  <= '0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign sched.rsp_valid  = rsp_valid_r;
  assign sched.rsp_error  = err_r;
  assign sched.rsp_matrix = result_r;
  assign sched.busy       = busy_r;
  assign core_start       = core_start_r;
  assign core_op_select   = op_r;
  assign core_input1      = m1_r;
  assign core_input2      = m2_r;

endmodule

// Protocol properties of the scheduler, kept apart from the datapath.
module tensor_core_scheduler_checker #(
  parameter int NUM_REQUESTERS = 2
) (
  input logic                      clk,
  input logic                      rst,
  input logic [NUM_REQUESTERS-1:0] req_ready,
  input logic [NUM_REQUESTERS-1:0] rsp_valid,
  input logic                      core_start,
  input logic                      busy
);

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));
  a_start_busy:   assert property (@(posedge clk) disable iff (rst) core_start |-> busy);
  a_start_pulse:  assert property (@(posedge clk) disable iff (rst) core_start |=> !core_start);

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// Scoreboard bench for tensor_core_scheduler with a latency-accurate tensor core stand-in.
module tb_tensor_core_scheduler;

  localparam int N   = 2;
  localparam int DW  = 8;
  localparam int LAT = 11;

  typedef logic [2:0][2:0][DW-1:0] mat_t;
  typedef struct { logic [2:0] op; mat_t m1; mat_t m2; logic err; mat_t res; } job_t;
  typedef struct { int id; logic err; mat_t mat; int acc; int lat; } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       core_start;
  logic [2:0] core_op;
  mat_t       core_in1, core_in2, core_out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int starts   = 0;
  int core_rem;
  int grant_log[$];
  exp_t exp_q[$];
  job_t pend0[$];
  job_t pend1[$];
  logic [N-1:0] prev_valid;
  mat_t prev_mat;

  tensor_core_scheduler_if #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW)) sif ();

  tensor_core_scheduler #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .CORE_LATENCY(LAT)) dut (
    .clock_in      (clk),
    .reset_in      (rst),
    .sched         (sif),
    .core_start    (core_start),
    .core_op_select(core_op),
    .core_input1   (core_in1),
    .core_input2   (core_in2),
    .core_output   (core_out)
  );

  tensor_core_scheduler_checker #(.NUM_REQUESTERS(N)) u_chk (
    .clk(clk), .rst(rst), .req_ready(sif.req_ready), .rsp_valid(sif.rsp_valid),
    .core_start(core_start), .busy(sif.busy)
  );

  always #5 clk = ~clk;

  function automatic mat_t fill(input logic [7:0] v);
    mat_t r;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) r[i][j] = v;
    return r;
  endfunction

  function automatic mat_t mk9(input int a, b, c, d, e, f, g, h, k);
    mat_t r;
    r[0][0] = 8'(a); r[0][1] = 8'(b); r[0][2] = 8'(c);
    r[1][0] = 8'(d); r[1][1] = 8'(e); r[1][2] = 8'(f);
    r[2][0] = 8'(g); r[2][1] = 8'(h); r[2][2] = 8'(k);
    return r;
  endfunction

  function automatic job_t mkjob(input logic [2:0] op, input mat_t m1, m2, input logic err, input mat_t res);
    job_t j;
    j.op = op; j.m1 = m1; j.m2 = m2; j.err = err; j.res = res;
    return j;
  endfunction

  function automatic mat_t core_func(input logic [2:0] op, input mat_t a, input mat_t b);
    mat_t r;
    logic signed [15:0] p;
    logic signed [15:0] acc;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        acc = '0;
        for (int k = 0; k < 3; k++) begin
          p   = $signed(a[i][k]) * $signed(b[k][j]);
          acc = acc + p;
        end
        case (op)
          3'b000:  r[i][j] = acc[7:0];
          3'b001:  r[i][j] = a[i][j] + b[i][j];
          3'b010:  r[i][j] = a[i][j][7] ? 8'h00 : a[i][j];
          default: r[i][j] = 8'hEE;
        endcase
      end
    end
    return r;
  endfunction

  function automatic void check(input string name, input logic [95:0] act, input logic [95:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, expv);
  endfunction

  // Core stand-in: junk output until the latency has elapsed after a start pulse
  always @(posedge clk or posedge rst) begin
    if (rst) core_rem <= 0;
    else if (core_start) core_rem <= LAT;
    else if (core_rem > 0) core_rem <= core_rem - 1;
  end

  always_comb begin
    core_out = {9{8'h5A}};
    if (core_rem <= 1) core_out = core_func(core_op, core_in1, core_in2);
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!rst && core_start) starts <= starts + 1;

  // Monitor: latency at rising valid, stability while pending, contents at handshake
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= '0;
    end else begin
      if (sif.rsp_valid != 2'b00 && prev_valid == 2'b00) begin
        if (exp_q.size() == 0) check("unexpected_rsp", 96'(sif.rsp_valid), 96'(0));
        else check("rsp_latency", 96'(cyc - exp_q[0].acc), 96'(exp_q[0].lat));
      end
      if (sif.rsp_valid != 2'b00 && prev_valid != 2'b00)
        check("rsp_stable", 96'(sif.rsp_matrix), 96'(prev_mat));
      if ((sif.rsp_valid & sif.rsp_ready) != 2'b00 && exp_q.size() != 0) begin
        check("rsp_id", 96'(sif.rsp_valid), 96'(2'b01 << exp_q[0].id));
        check("rsp_error", 96'(sif.rsp_error), 96'(exp_q[0].err));
        check("rsp_matrix", 96'(sif.rsp_matrix), 96'(exp_q[0].mat));
        void'(exp_q.pop_front());
      end
      prev_valid <= sif.rsp_valid;
      prev_mat   <= sif.rsp_matrix;
    end
  end

  task automatic drive_reqs();
    sif.req_valid = {pend1.size() != 0, pend0.size() != 0};
    if (pend0.size() != 0) begin
      sif.req_op[0] = pend0[0].op; sif.req_matrix1[0] = pend0[0].m1; sif.req_matrix2[0] = pend0[0].m2;
    end
    if (pend1.size() != 0) begin
      sif.req_op[1] = pend1[0].op; sif.req_matrix1[1] = pend1[0].m1; sif.req_matrix2[1] = pend1[0].m2;
    end
  endtask

  task automatic step();
    int g;
    job_t j;
    exp_t e;
    g = -1;
    @(negedge clk);
    if (!rst) for (int i = 0; i < N; i++) if (sif.req_valid[i] && sif.req_ready[i]) g = i;
    if (g >= 0) begin
      j = (g == 0) ? pend0[0] : pend1[0];
      e.id = g; e.err = j.err; e.mat = j.res; e.acc = cyc; e.lat = j.err ? 1 : LAT + 2;
      exp_q.push_back(e);
      grant_log.push_back(g);
    end
    @(posedge clk);
    #1;
    if (g == 0) void'(pend0.pop_front());
    if (g == 1) void'(pend1.pop_front());
    drive_reqs();
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while ((pend0.size() != 0 || pend1.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain", 96'(pend0.size() + pend1.size() + exp_q.size()), 96'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_grants[4];
    int s0;
    int n;
    exp_grants = '{0, 1, 0, 1};
    rst = 1'b1;
    sif.rsp_ready   = 2'b11;
    sif.req_valid   = 2'b00;
    sif.req_op      = '0;
    sif.req_matrix1 = '0;
    sif.req_matrix2 = '0;

    // Contention jobs queued from reset; client 1's second job arrives during client 0's run
    pend0.push_back(mkjob(3'b001, fill(8'd1), fill(8'd2), 1'b0, fill(8'd3)));
    pend0.push_back(mkjob(3'b010, mk9(-5, 0, 7, -1, 2, -128, 127, 3, -9), fill(8'd9), 1'b0,
                          mk9(0, 0, 7, 0, 2, 0, 127, 3, 0)));
    pend1.push_back(mkjob(3'b000, fill(8'd1), fill(8'd2), 1'b0, fill(8'd6)));
    drive_reqs();
    repeat (2) @(posedge clk);
    #2;
    check("reset_req_ready", 96'(sif.req_ready), 96'(0));
    check("reset_rsp_valid", 96'(sif.rsp_valid), 96'(0));
    check("reset_busy", 96'(sif.busy), 96'(0));
    check("reset_core_start", 96'(core_start), 96'(0));
    check("reset_rsp_error", 96'(sif.rsp_error), 96'(0));
    check("reset_rsp_matrix", 96'(sif.rsp_matrix), 96'(0));
    check("reset_core_input1", 96'(core_in1), 96'(0));
    check("reset_core_input2", 96'(core_in2), 96'(0));
    check("reset_core_op", 96'(core_op), 96'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    repeat (5) step();
    pend1.push_back(mkjob(3'b001, fill(8'd100), fill(8'd100), 1'b0, fill(8'hC8)));
    drive_reqs();
    run_until_done(200);
    check("grant_count", 96'(grant_log.size()), 96'(4));
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check($sformatf("grant_order_%0d", k), 96'(grant_log[k]), 96'(exp_grants[k]));

    // Single multiply by identity
    s0 = starts;
    pend0.push_back(mkjob(3'b000, mk9(1, 0, 0, 0, 1, 0, 0, 0, 1), mk9(1, 2, 3, 4, 5, 6, 7, 8, 9),
                          1'b0, mk9(1, 2, 3, 4, 5, 6, 7, 8, 9)));
    drive_reqs();
    run_until_done(60);
    check("legal_start_pulses", 96'(starts - s0), 96'(1));

    // Illegal op: no core launch, zero matrix with error
    s0 = starts;
    pend1.push_back(mkjob(3'b101, fill(8'd7), fill(8'd3), 1'b1, fill(8'd0)));
    drive_reqs();
    run_until_done(20);
    check("illegal_start_pulses", 96'(starts - s0), 96'(0));

    // Response backpressure; ready on the other index must not complete it
    sif.rsp_ready = 2'b10;
    pend0.push_back(mkjob(3'b001, fill(8'd1), fill(8'd1), 1'b0, fill(8'd2)));
    drive_reqs();
    n = 0;
    while (pend0.size() != 0 && n < 10) begin step(); n++; end
    pend1.push_back(mkjob(3'b001, fill(8'd5), fill(8'd250), 1'b0, fill(8'hFF)));
    drive_reqs();
    n = 0;
    while (!sif.rsp_valid[0] && n < 40) begin step(); n++; end
    check("bp_rsp_valid", 96'(sif.rsp_valid), 96'(2'b01));
    for (int k = 0; k < 20; k++) begin
      step();
      check("bp_busy", 96'(sif.busy), 96'(1));
      check("bp_req_ready", 96'(sif.req_ready), 96'(0));
    end
    sif.rsp_ready = 2'b11;
    step();
    check("bp_idle_busy", 96'(sif.busy), 96'(0));
    check("bp_idle_grant", 96'(sif.req_ready), 96'(2'b10));
    run_until_done(60);

    // Reset in the middle of a run
    pend0.push_back(mkjob(3'b001, fill(8'd1), fill(8'd1), 1'b0, fill(8'd2)));
    drive_reqs();
    n = 0;
    while (pend0.size() != 0 && n < 10) begin step(); n++; end
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 96'(sif.busy), 96'(0));
    check("midrst_core_start", 96'(core_start), 96'(0));
    check("midrst_rsp_valid", 96'(sif.rsp_valid), 96'(0));
    check("midrst_req_ready", 96'(sif.req_ready), 96'(0));
    check("midrst_core_input1", 96'(core_in1), 96'(0));
    check("midrst_core_op", 96'(core_op), 96'(0));
    check("midrst_rsp_matrix", 96'(sif.rsp_matrix), 96'(0));
    exp_q.delete();
    pend0.delete();
    pend1.delete();
    drive_reqs();
    @(posedge clk);
    #1 rst = 1'b0;
    pend0.push_back(mkjob(3'b000, mk9(2, 0, 0, 0, 2, 0, 0, 0, 2), mk9(1, 2, 3, 4, 5, 6, 7, 8, 9),
                          1'b0, mk9(2, 4, 6, 8, 10, 12, 14, 16, 18)));
    drive_reqs();
    run_until_done(60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
